// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared types for the two-channel packet stream arbiter
package stream_mux_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_e;

endpackage

// File: rtl/mux2_w.sv
// rtl/mux2_w.sv - WIDTH-bit 2:1 payload select
module mux2_w #(
    parameter int WIDTH = 8
) (
    input  logic             sel_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);

    assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/stream_mux_arbiter.sv
// rtl/stream_mux_arbiter.sv - two-channel stream mux with per-packet round-robin arbitration
module stream_mux_arbiter
    import stream_mux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_last,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_src
);

    state_e           state_q, state_d;
    logic             prio_q, prio_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic             out_src_q, out_src_d;

    logic             grant0, grant1;
    logic             load, accept, sel, last_sel;
    logic [WIDTH-1:0] data_sel;

    mux2_w #(.WIDTH(WIDTH)) u_mux (
        .sel_i (sel),
        .a_i   (in0_data),
        .b_i   (in1_data),
        .y_o   (data_sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
        end
    end

    always_comb begin
        grant0      = 1'b0;
        grant1      = 1'b0;
        state_d     = state_q;
        prio_d      = prio_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;

        unique case (state_q)
            IDLE: begin
                if (in0_valid && in1_valid) begin
                    grant0 = !prio_q;
                    grant1 = prio_q;
                end else begin
                    grant0 = in0_valid;
                    grant1 = in1_valid;
                end
            end
            LOCK0:   grant0 = in0_valid;
            LOCK1:   grant1 = in1_valid;
            default: ;
        endcase

        load = !out_valid_q || out_ready;
        // Ready is gated by rst_n so both inputs stall while reset is asserted.
        in0_ready = rst_n && load && grant0;
        in1_ready = rst_n && load && grant1;
        accept    = in0_ready || in1_ready;
        sel       = grant1;
        last_sel  = grant1 ? in1_last : in0_last;

        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = data_sel;
            out_last_d  = last_sel;
            out_src_d   = sel;
            if (last_sel) begin
                state_d = IDLE;
                prio_d  = !sel;
            end else begin
                state_d = sel ? LOCK1 : LOCK0;
            end
        end else if (load) begin
            out_valid_d = 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_stream_mux_arbiter.sv
// tb/tb_stream_mux_arbiter.sv - directed self-checking bench for stream_mux_arbiter
module tb_stream_mux_arbiter;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in0_valid, in0_ready, in0_last;
    logic [WIDTH-1:0] in0_data;
    logic             in1_valid, in1_ready, in1_last;
    logic [WIDTH-1:0] in1_data;
    logic             out_valid, out_ready, out_last, out_src;
    logic [WIDTH-1:0] out_data;

    int n_cmp  = 0;
    int n_fail = 0;

    stream_mux_arbiter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in0_data  (in0_data),
        .in0_last  (in0_last),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in1_data  (in1_data),
        .in1_last  (in1_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in0_valid = 1'b0; in0_data = '0; in0_last = 1'b0;
        in1_valid = 1'b0; in1_data = '0; in1_last = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        rst_n = 1'b0;
        #3;
        n_cmp++; if (in0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in0_ready: got %b required 0", in0_ready); end
        n_cmp++; if (in1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in1_ready: got %b required 0", in1_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h required 00", out_data); end
        n_cmp++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b required 0", out_last); end
        n_cmp++; if (out_src !== 1'b0) begin n_fail++; $display("FAIL reset_out_src: got %b required 0", out_src); end
        clear_inputs();
    endtask

    task automatic test_single_beat();
        do_reset();
        in0_valid = 1'b1; in0_data = 8'h11; in0_last = 1'b1;
        #1;
        n_cmp++; if (in0_ready !== 1'b1) begin n_fail++; $display("FAIL single_in0_ready: got %b required 1", in0_ready); end
        tick();
        in0_valid = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_out_valid: got %b required 1", out_valid); end
        n_cmp++; if (out_data !== 8'h11) begin n_fail++; $display("FAIL single_out_data: got %h required 11", out_data); end
        n_cmp++; if (out_src !== 1'b0) begin n_fail++; $display("FAIL single_out_src: got %b required 0", out_src); end
        n_cmp++; if (out_last !== 1'b1) begin n_fail++; $display("FAIL single_out_last: got %b required 1", out_last); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain_valid: got %b required 0", out_valid); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_src;
        logic [7:0] exp_data;
        exp_src = 4'b1010;
        do_reset();
        in0_valid = 1'b1; in0_data = 8'hA0; in0_last = 1'b1;
        in1_valid = 1'b1; in1_data = 8'hB0; in1_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if ((in0_ready !== !exp_src[i]) || (in1_ready !== exp_src[i])) begin
                n_fail++;
                $display("FAIL rr_ready[%0d]: got in0=%b in1=%b required grant to ch%0d", i, in0_ready, in1_ready, exp_src[i]);
            end
            tick();
            exp_data = exp_src[i] ? 8'hB0 : 8'hA0;
            n_cmp++;
            if ((out_valid !== 1'b1) || (out_src !== exp_src[i]) || (out_data !== exp_data)) begin
                n_fail++;
                $display("FAIL rr_beat[%0d]: got v=%b src=%b data=%h required v=1 src=%b data=%h",
                         i, out_valid, out_src, out_data, exp_src[i], exp_data);
            end
        end
        clear_inputs();
    endtask

    task automatic test_lock();
        do_reset();
        in1_valid = 1'b1; in1_data = 8'h01; in1_last = 1'b0;
        #1;
        n_cmp++; if (in1_ready !== 1'b1) begin n_fail++; $display("FAIL lock_first_ready: got %b required 1", in1_ready); end
        tick();
        in0_valid = 1'b1; in0_data = 8'hC0; in0_last = 1'b1;
        in1_data = 8'h02;
        #1;
        n_cmp++; if (in0_ready !== 1'b0) begin n_fail++; $display("FAIL lock_beat2_in0_ready: got %b required 0", in0_ready); end
        n_cmp++; if (in1_ready !== 1'b1) begin n_fail++; $display("FAIL lock_beat2_in1_ready: got %b required 1", in1_ready); end
        tick();
        n_cmp++; if (out_data !== 8'h02 || out_src !== 1'b1 || out_last !== 1'b0) begin
            n_fail++; $display("FAIL lock_beat2_out: got data=%h src=%b last=%b required 02/1/0", out_data, out_src, out_last); end
        in1_valid = 1'b0;
        #1;
        n_cmp++; if (in0_ready !== 1'b0) begin n_fail++; $display("FAIL lock_gap_in0_ready: got %b required 0", in0_ready); end
        tick();
        in1_valid = 1'b1; in1_data = 8'h03; in1_last = 1'b1;
        #1;
        n_cmp++; if (in0_ready !== 1'b0) begin n_fail++; $display("FAIL lock_beat3_in0_ready: got %b required 0", in0_ready); end
        tick();
        n_cmp++; if (out_data !== 8'h03 || out_src !== 1'b1 || out_last !== 1'b1) begin
            n_fail++; $display("FAIL lock_beat3_out: got data=%h src=%b last=%b required 03/1/1", out_data, out_src, out_last); end
        in1_valid = 1'b0;
        #1;
        n_cmp++; if (in0_ready !== 1'b1) begin n_fail++; $display("FAIL lock_release_in0_ready: got %b required 1", in0_ready); end
        tick();
        n_cmp++; if (out_data !== 8'hC0 || out_src !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL lock_after_out: got data=%h src=%b v=%b required C0/0/1", out_data, out_src, out_valid); end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        do_reset();
        in0_valid = 1'b1; in0_data = 8'h5A; in0_last = 1'b1;
        tick();
        out_ready = 1'b0;
        in0_data = 8'h77;
        in1_valid = 1'b1; in1_data = 8'h66; in1_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_ready[%0d]: got in0=%b in1=%b required 0 0", i, in0_ready, in1_ready); end
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== 8'h5A || out_src !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got v=%b data=%h src=%b required 1/5A/0", i, out_valid, out_data, out_src); end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in1_ready !== 1'b1 || in0_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_release_ready: got in0=%b in1=%b required 0 1", in0_ready, in1_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h66 || out_src !== 1'b1) begin
            n_fail++; $display("FAIL bp_next_beat: got v=%b data=%h src=%b required 1/66/1", out_valid, out_data, out_src); end
        clear_inputs();
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        in1_valid = 1'b1; in1_data = 8'h01; in1_last = 1'b0;
        tick();
        in0_valid = 1'b1; in0_data = 8'hD0; in0_last = 1'b1;
        in1_data = 8'h02;
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_src !== 1'b0 || out_last !== 1'b0) begin
            n_fail++; $display("FAIL midrst_outputs: got v=%b data=%h src=%b last=%b required 0/00/0/0", out_valid, out_data, out_src, out_last); end
        n_cmp++; if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
            n_fail++; $display("FAIL midrst_ready: got in0=%b in1=%b required 0 0", in0_ready, in1_ready); end
        tick();
        #2;
        rst_n = 1'b1;
        #1;
        n_cmp++; if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin
            n_fail++; $display("FAIL midrst_grant: got in0=%b in1=%b required 1 0", in0_ready, in1_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'hD0 || out_src !== 1'b0) begin
            n_fail++; $display("FAIL midrst_first_beat: got v=%b data=%h src=%b required 1/D0/0", out_valid, out_data, out_src); end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        test_reset();
        test_single_beat();
        test_round_robin();
        test_lock();
        test_backpressure();
        test_reset_mid_packet();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_mux_arbiter.md
STREAM_MUX_ARBITER -- requirements
Module: stream_mux_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, payload width in bits.
REQ-002 Ports, in order: clk  in  1  sole clock, rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 in0_valid  in  1  channel 0 beat present.
REQ-005 in0_ready  out  1  channel 0 beat accepted this cycle when high with in0_valid.
REQ-006 in0_data  in  WIDTH  channel 0 payload.
REQ-007 in0_last  in  1  channel 0 final beat of packet.
REQ-008 in1_valid, in1_ready, in1_data, in1_last: same as REQ-004..REQ-007 for channel 1.
REQ-009 out_valid  out  1  output beat present.
REQ-010 out_ready  in  1  downstream accepts the output beat.
REQ-011 out_data  out  WIDTH  selected payload.
REQ-012 out_last  out  1  copy of the selected input's last.
REQ-013 out_src  out  1  source of the output beat: 0 = channel 0, 1 = channel 1.

Function
REQ-014 A beat transfers on a channel when valid and ready are both high at a rising clk edge.
REQ-015 load = !out_valid || out_ready.
REQ-016 inX_ready = load && grant_X; at most one grant is high per cycle.
REQ-017 On an accepted input beat, out_data, out_last and out_src load from the granted channel and out_valid sets, giving 1-cycle latency.
REQ-018 When load is high and no input is accepted, out_valid clears.
REQ-019 When load is low, all output registers hold.
REQ-020 FSM states: IDLE, LOCK0, LOCK1.
REQ-021 IDLE grant:
- only one channel valid: that channel is granted.
- both channels valid: the channel selected by pointer prio is granted.
- neither channel valid: no grant.
REQ-022 IDLE -> LOCKx on an accepted beat from channel x with last = 0; IDLE holds on an accepted beat with last = 1.
REQ-023 In LOCKx, only channel x is granted; channel x's valid is the sole condition; the other channel is stalled regardless of its valid.
REQ-024 LOCKx -> IDLE on an accepted beat from channel x with last = 1.
REQ-025 On every accepted beat with last = 1, prio is set to the other channel (round-robin per packet).
REQ-026 A single-beat packet (last = 1 on the first beat) never enters LOCK.
REQ-027 Simultaneous output drain and input accept in one cycle produce back-to-back beats with no bubble.
REQ-028 Input valid, data and last are not required to stay stable while ready is low; the block samples them only on transfer.
REQ-029 Output beat stability: while out_valid = 1 and out_ready = 0, out_data, out_last and out_src hold unchanged.

Reset
REQ-030 While rst_n = 0:
- out_valid = 0, out_data = 0, out_last = 0, out_src = 0.
- state = IDLE, prio = channel 0.
- in0_ready = 0 and in1_ready = 0.
REQ-031 Assertion mid-packet abandons the lock and drops any held output beat; the first accepted beat after release is arbitrated from IDLE.

Structure
REQ-032 A shared package stream_mux_pkg holds the FSM state enum (IDLE, LOCK0, LOCK1).
REQ-033 Payload selection uses one sub-module instance, mux2_w (WIDTH-bit 2:1 select, sel = granted channel).
REQ-034 Grant logic is combinational; the FSM, prio and output registers are the only state.

Verification
REQ-035 Reset release, then in0 one beat (data 0x11, last 1), out_ready 1 -> next cycle out_valid 1, out_data 0x11, out_src 0, out_last 1.
REQ-036 Both channels valid with single-beat packets (0xA0 / 0xB0) for 4 cycles, out_ready 1 -> out_src sequence 0,1,0,1; every beat accepted with no bubble.
REQ-037 in1 three-beat packet 0x01, 0x02, 0x03 (last on 0x03) with in0 continuously valid -> in0_ready stays 0 until 0x03 is accepted, then in0 is granted next.
REQ-038 out_ready held 0 for 3 cycles with 0x5A loaded -> out_data stays 0x5A, in0_ready and in1_ready stay 0; out_ready high -> 0x5A drains, next beat loads in the same cycle.
REQ-039 rst_n pulsed low during LOCK1 mid-packet -> outputs return to REQ-030 values immediately; after release, with both valid, in0 is granted first.
